// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter and
// Moore edge FSM, with per-channel polarity select and saturating event counter.
module edge_detect_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [N_CH-1:0]       level,
  input  logic [2*N_CH-1:0]     edge_sel,
  input  logic [N_CH-1:0]       cnt_clr,
  output logic [N_CH-1:0]       filt_level,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       fall,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH*CNT_W-1:0] evt_cnt
);

  localparam int STAB_W = $clog2(FILT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tick_c;

    // Shift the raw pin through the synchroniser chain
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= (sync_q << 1) | SYNC_STAGES'(level[i]);
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        state_q <= LOW;
        stab_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        stab_q  <= stab_d;
        cnt_q   <= cnt_d;
      end
    end

    // Stab only runs while s disagrees with the committed level; any agreeing
    // cycle restarts it, which is what rejects short glitches.
    always_comb begin
      state_d = state_q;
      stab_d  = '0;
      case (state_q)
        LOW: begin
          if (s) begin
            if (stab_q == STAB_LAST) state_d = RISE;
            else                     stab_d  = stab_q + STAB_W'(1);
          end
        end
        RISE: state_d = HIGH;
        HIGH: begin
          if (!s) begin
            if (stab_q == STAB_LAST) state_d = FALL;
            else                     stab_d  = stab_q + STAB_W'(1);
          end
        end
        FALL: state_d = LOW;
        default: state_d = LOW;
      endcase
    end

    assign rise[i]       = (state_q == RISE);
    assign fall[i]       = (state_q == FALL);
    assign filt_level[i] = (state_q == RISE) || (state_q == HIGH);
    assign tick_c        = ((state_q == RISE) && edge_sel[2*i]) ||
                           ((state_q == FALL) && edge_sel[2*i+1]);
    assign tick[i]       = tick_c;

    // A clear coinciding with a tick keeps that tick's event
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr[i])                        cnt_d = CNT_W'(tick_c);
      else if (tick_c && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    end

    assign evt_cnt[CNT_W*i +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: directed table, corner sequences
// and a randomized run compared against a sample-window reference model.
module tb_edge_detect_multi;

  localparam int NCH   = 4;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int RANDN = 1500;

  logic        CLK;
  logic        reset;
  logic [3:0]  level;
  logic [7:0]  edgeSel;
  logic [3:0]  cntClr;
  logic [3:0]  filtLevel, rise, fall, tick;
  logic [31:0] evtCnt;

  logic        levelB;
  logic [1:0]  selB;
  logic        clrB;
  logic        filtB, riseB, fallB, tickB;
  logic [1:0]  cntB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       lvl;
    logic       rise;
    logic       fall;
    logic       tick;
    logic       filt;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[16];

  bit lvlHist[NCH][RANDN];
  bit sHist[NCH][RANDN];
  bit acc[NCH];
  int lastAcc[NCH];
  bit pRise[NCH];
  bit pFall[NCH];
  int mCnt[NCH];

  edge_detect_multi dut (
    .CLK(CLK), .reset(reset), .level(level), .edge_sel(edgeSel), .cnt_clr(cntClr),
    .filt_level(filtLevel), .rise(rise), .fall(fall), .tick(tick), .evt_cnt(evtCnt)
  );

  edge_detect_multi #(.N_CH(1), .CNT_W(2)) dutSat (
    .CLK(CLK), .reset(reset), .level(levelB), .edge_sel(selB), .cnt_clr(clrB),
    .filt_level(filtB), .rise(riseB), .fall(fallB), .tick(tickB), .evt_cnt(cntB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after an edge, outputs sampled 1 unit after the next
  task automatic applyStimulus();
    @(posedge CLK);
    #1;
  endtask

  task automatic resetDut();
    reset   = 1'b1;
    level   = '0;
    edgeSel = '0;
    cntClr  = '0;
    levelB  = 1'b0;
    selB    = '0;
    clrB    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  // Reference: an edge is accepted at sample t when the last FILT synchronised
  // samples all oppose the accepted level and none falls in the cycle of, or the
  // cycle after, the previous acceptance.
  task automatic modelStep(input int t, output logic [3:0] eFilt, output logic [3:0] eRise,
                           output logic [3:0] eFall, output logic [3:0] eTick,
                           output logic [31:0] eCnt);
    bit ok;
    bit tp;
    for (int ch = 0; ch < NCH; ch++) begin
      lvlHist[ch][t] = level[ch];
      sHist[ch][t]   = (t >= SYNC) ? lvlHist[ch][t-SYNC] : 1'b0;
      tp = (pRise[ch] && edgeSel[2*ch]) || (pFall[ch] && edgeSel[2*ch+1]);
      if (cntClr[ch])           mCnt[ch] = tp ? 1 : 0;
      else if (tp && mCnt[ch] < 255) mCnt[ch]++;
      ok = 1'b1;
      for (int j = 0; j < FILT; j++)
        if ((t - j < lastAcc[ch] + 2) || (sHist[ch][t-j] == acc[ch])) ok = 1'b0;
      pRise[ch] = ok && !acc[ch];
      pFall[ch] = ok && acc[ch];
      if (ok) begin
        acc[ch]     = !acc[ch];
        lastAcc[ch] = t;
      end
      eFilt[ch] = acc[ch];
      eRise[ch] = pRise[ch];
      eFall[ch] = pFall[ch];
      eTick[ch] = (pRise[ch] && edgeSel[2*ch]) || (pFall[ch] && edgeSel[2*ch+1]);
      eCnt[8*ch +: 8] = 8'(mCnt[ch]);
    end
  endtask

  initial begin
    int nRise, nFall, nTick1, nTick2, nFilt, nTick0;
    logic [3:0]  eFilt, eRise, eFall, eTick;
    logic [31:0] eCnt;

    vecs = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}
    };

    reset   = 1'b1;
    level   = '0;
    edgeSel = '0;
    cntClr  = '0;
    levelB  = 1'b0;
    selB    = '0;
    clrB    = 1'b0;
    #3;
    checkOutput("reset_filt", 32'(filtLevel), 32'h0);
    checkOutput("reset_pulses", 32'({rise, fall, tick}), 32'h0);
    checkOutput("reset_cnt", evtCnt, 32'h0);
    checkOutput("reset_sat", 32'({filtB, riseB, fallB, tickB, cntB}), 32'h0);

    // Directed table: channel 0 rising mode, one full pulse
    resetDut();
    edgeSel = 8'h01;
    for (int k = 0; k < 16; k++) begin
      level = {3'b000, vecs[k].lvl};
      applyStimulus();
      checkOutput($sformatf("tbl%0d_rise", k), 32'(rise[0]), 32'(vecs[k].rise));
      checkOutput($sformatf("tbl%0d_fall", k), 32'(fall[0]), 32'(vecs[k].fall));
      checkOutput($sformatf("tbl%0d_tick", k), 32'(tick[0]), 32'(vecs[k].tick));
      checkOutput($sformatf("tbl%0d_filt", k), 32'(filtLevel[0]), 32'(vecs[k].filt));
      checkOutput($sformatf("tbl%0d_cnt", k), 32'(evtCnt[7:0]), 32'(vecs[k].cnt));
    end

    // Glitch: 3-cycle pulse rejected, 4-cycle pulse accepted once
    resetDut();
    edgeSel = 8'h01;
    nRise = 0; nTick0 = 0; nFilt = 0; nFall = 0;
    for (int k = 0; k < 15; k++) begin
      level = (k < 3) ? 4'h1 : 4'h0;
      applyStimulus();
      nRise += rise[0]; nTick0 += tick[0]; nFilt += filtLevel[0];
    end
    checkOutput("glitch3_rise", 32'(nRise), 32'd0);
    checkOutput("glitch3_tick", 32'(nTick0), 32'd0);
    checkOutput("glitch3_filt", 32'(nFilt), 32'd0);
    nRise = 0;
    for (int k = 0; k < 20; k++) begin
      level = (k < 4) ? 4'h1 : 4'h0;
      applyStimulus();
      nRise += rise[0]; nFall += fall[0];
    end
    checkOutput("pulse4_rise", 32'(nRise), 32'd1);
    checkOutput("pulse4_fall", 32'(nFall), 32'd1);
    checkOutput("pulse4_cnt", 32'(evtCnt[7:0]), 32'd1);

    // Both-edge on ch2, disabled ch1, same three pulses
    resetDut();
    edgeSel = 8'b0011_0000;
    nRise = 0; nFall = 0; nTick1 = 0; nTick2 = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 16; k++) begin
        level = (k < 8) ? 4'b0110 : 4'b0000;
        applyStimulus();
        nRise += rise[1]; nFall += fall[1]; nTick1 += tick[1]; nTick2 += tick[2];
      end
    end
    repeat (4) applyStimulus();
    checkOutput("both_tick2", 32'(nTick2), 32'd6);
    checkOutput("both_cnt2", 32'(evtCnt[23:16]), 32'd6);
    checkOutput("off_rise1", 32'(nRise), 32'd3);
    checkOutput("off_fall1", 32'(nFall), 32'd3);
    checkOutput("off_tick1", 32'(nTick1), 32'd0);
    checkOutput("off_cnt1", 32'(evtCnt[15:8]), 32'd0);

    // Saturation on the 2-bit counter instance
    resetDut();
    selB = 2'b01;
    for (int p = 1; p <= 8; p++) begin
      for (int k = 0; k < 16; k++) begin
        levelB = (k < 8);
        applyStimulus();
      end
      checkOutput($sformatf("sat_cnt%0d", p), 32'(cntB), (p < 3) ? 32'(p) : 32'd3);
    end
    levelB = 1'b1;
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("sat_tick", 32'(tickB), 32'd1);
    clrB = 1'b1;
    applyStimulus();
    checkOutput("clr_with_tick", 32'(cntB), 32'd1);
    clrB = 1'b0;
    levelB = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("hold_after_clr", 32'(cntB), 32'd1);
    clrB = 1'b1;
    applyStimulus();
    checkOutput("clr_alone", 32'(cntB), 32'd0);
    clrB = 1'b0;

    // All four channels rise together
    resetDut();
    edgeSel = 8'h55;
    level = 4'hF;
    for (int k = 0; k < 5; k++) applyStimulus();
    checkOutput("simul_pre_tick", 32'(tick), 32'h0);
    applyStimulus();
    checkOutput("simul_tick", 32'(tick), 32'hF);
    checkOutput("simul_rise", 32'(rise), 32'hF);
    applyStimulus();
    checkOutput("simul_cnt", evtCnt, 32'h01010101);
    cntClr = 4'b0001;
    applyStimulus();
    cntClr = 4'b0000;
    checkOutput("simul_indep_clr", evtCnt, 32'h01010100);

    // Reset during the RISE cycle, then release with level held high
    resetDut();
    edgeSel = 8'h01;
    level = 4'h1;
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("midrst_pre_tick", 32'(tick[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_tick", 32'(tick), 32'h0);
    checkOutput("midrst_outs", 32'({filtLevel, rise, fall}), 32'h0);
    checkOutput("midrst_cnt", evtCnt, 32'h0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      checkOutput($sformatf("relrise_e%0d", k), 32'(rise[0]), (k == 5) ? 32'd1 : 32'd0);
    end
    checkOutput("relrise_tick", 32'(tick[0]), 32'd1);

    // Randomized run against the reference model
    resetDut();
    for (int ch = 0; ch < NCH; ch++) begin
      acc[ch] = 1'b0; lastAcc[ch] = -2; pRise[ch] = 1'b0; pFall[ch] = 1'b0; mCnt[ch] = 0;
    end
    for (int t = 0; t < RANDN; t++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 5) == 0) level[ch] = ~level[ch];
        cntClr[ch] = ($urandom_range(0, 29) == 0);
      end
      if ($urandom_range(0, 19) == 0) edgeSel = 8'($urandom);
      applyStimulus();
      modelStep(t, eFilt, eRise, eFall, eTick, eCnt);
      checkOutput($sformatf("rnd%0d_filt", t), 32'(filtLevel), 32'(eFilt));
      checkOutput($sformatf("rnd%0d_rise", t), 32'(rise), 32'(eRise));
      checkOutput($sformatf("rnd%0d_fall", t), 32'(fall), 32'(eFall));
      checkOutput($sformatf("rnd%0d_tick", t), 32'(tick), 32'(eTick));
      checkOutput($sformatf("rnd%0d_cnt", t), evtCnt, eCnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
# edge_detect_multi

Parametrised multi-channel edge detector: each of N_CH asynchronous level inputs is synchronised, glitch-filtered and passed through a per-channel Moore FSM that emits single-cycle edge ticks. Edge polarity is selected per channel, and each channel keeps a saturating event counter. The block sits between raw pins (buttons, strobes, external flags) and the synchronous control logic that consumes one-cycle event pulses.

## Interface
- N_CH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥1)
- FILT_CYCLES, 4, consecutive cycles a new synchronised level must hold before it is accepted (≥1; 1 = no filtering)
- CNT_W, 8, event counter width per channel (≥1)
- CLK  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- level  in  N_CH  raw asynchronous inputs, bit i = channel i
- edge_sel  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- cnt_clr  in  N_CH  synchronous per-channel counter clear
- filt_level  out  N_CH  accepted (filtered) level per channel
- rise  out  N_CH  one-cycle pulse on accepted rising edge, regardless of edge_sel
- fall  out  N_CH  one-cycle pulse on accepted falling edge, regardless of edge_sel
- tick  out  N_CH  tick[i] = (rise[i] & edge_sel[2i]) | (fall[i] & edge_sel[2i+1])
- evt_cnt  out  N_CH*CNT_W  per-channel event count, channel i at [CNT_W*i +: CNT_W]

## Operation
- Synchroniser: level[i] shifts through SYNC_STAGES flops; last stage s[i] is the only value the filter and FSM see.
- Per-channel FSM states: LOW, RISE, HIGH, FALL. Reset state LOW.
- Stability counter stab (width clog2(FILT_CYCLES+1)): in LOW, counts cycles with s=1; in HIGH, counts cycles with s=0; cleared on any cycle where s equals the committed level, and in RISE/FALL.
- LOW: s=1 and stab==FILT_CYCLES-1 -> RISE; otherwise stay.
- RISE: rise=1 (Moore output); unconditionally -> HIGH.
- HIGH: s=0 and stab==FILT_CYCLES-1 -> FALL; otherwise stay.
- FALL: fall=1; unconditionally -> LOW.
- filt_level = 1 in RISE and HIGH, 0 in LOW and FALL.
- Glitch rule: any s excursion shorter than FILT_CYCLES cycles produces no edge and restarts stab from 0.
- Counter: increments by 1 on tick[i], saturates at 2^CNT_W-1 (no wrap). cnt_clr[i] sets it to 0; cnt_clr and tick in the same cycle yields 1 (event never lost).
- edge_sel changes take effect the same cycle (tick is combinational from FSM state and edge_sel); FSM and rise/fall are unaffected by edge_sel.
- Channels are fully independent; simultaneous edges on several channels all tick in the same cycle.

## Timing
- Reset values: filt_level=0, rise=0, fall=0, tick=0, evt_cnt=0, all sync flops 0, stab=0.
- reset assertion mid-operation clears everything asynchronously; an in-flight tick drops immediately; no tick is generated by reset itself.
- Latency: level change stable before posedge 0 -> rise/fall/tick high for exactly one cycle after posedge SYNC_STAGES+FILT_CYCLES-1 (defaults: after edge 5, i.e. the 6th clock).
- Minimum spacing between a rise and the following fall on one channel: FILT_CYCLES+1 cycles.
- evt_cnt updates on the posedge ending the tick cycle (counter lags tick by one cycle).
- level held high through reset release: treated as a rising edge; tick at the latency above.

## Test plan
- Defaults, edge_sel=01 ch0: level[0] 0->1 held -> rise[0]=tick[0]=1 for one cycle 6 clocks later, filt_level[0]=1, evt_cnt ch0=1; later 1->0 -> fall[0]=1, tick[0]=0, count stays 1.
- Glitch: level[0] high 3 cycles then low (FILT_CYCLES=4) -> no rise, no tick, filt_level stays 0; high 4 cycles -> exactly one rise.
- Both-edge mode, edge_sel=11 ch2, three full pulses -> six ticks, evt_cnt ch2=6; ch1 edge_sel=00 same stimulus -> rise/fall pulse, tick[1]=0, count 0.
- Saturation: CNT_W=2, eight rising edges -> count 1,2,3,3,...; cnt_clr coincident with a tick -> count=1; cnt_clr alone -> 0.
- Simultaneous channels: all four levels rise same cycle -> all four ticks in same cycle, independent counts.
- Reset mid-operation: assert reset during the RISE cycle -> tick drops immediately, all outputs 0; release with level high -> new rise after 6 clocks.
